// File: rtl/ddc_pkg.sv
// Shared constants, output pair type and the scale/round/saturate helper for the x2 mixer.
// Rounding mode is chosen at build time with DDC_MIXER_ROUND_EN (undefined: floor truncation).
package ddc_pkg;
   localparam int DDC_DATA_WIDTH = 16;
   localparam int DDC_COEF_WIDTH = 36;
   localparam int DDC_COEF_FRAC  = 34;
   localparam int DDC_OUT_WIDTH  = 18;
   localparam int DDC_ACC_W      = 64;

   typedef struct packed {
      logic signed [DDC_OUT_WIDTH-1:0] i;
      logic signed [DDC_OUT_WIDTH-1:0] q;
   } cplx_out_t;

   // Caller narrows the result to out_w bits; the value is already clamped to that range.
   function automatic logic signed [DDC_ACC_W-1:0] sat_round(
      input logic signed [DDC_ACC_W-1:0] p,
      input int frac,
      input int out_w);
      logic signed [DDC_ACC_W-1:0] s;
      logic signed [DDC_ACC_W-1:0] hi;
      logic signed [DDC_ACC_W-1:0] lo;
`ifdef DDC_MIXER_ROUND_EN
      s = (p + (64'sd1 <<< (frac - 1))) >>> frac;
`else
      s = p >>> frac;
`endif
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (s > hi)
         s = hi;
      else if (s < lo)
         s = lo;
      return s;
   endfunction
endpackage

// File: rtl/ddc_mixer_x2_if.sv
// Sample, DDS word and output handshake bundle of the two-lane mixer.
interface ddc_mixer_x2_if
   import ddc_pkg::*;
#(
   parameter int DATA_WIDTH = DDC_DATA_WIDTH,
   parameter int COEF_WIDTH = DDC_COEF_WIDTH,
   parameter int OUT_WIDTH  = DDC_OUT_WIDTH
);
   logic signed [DATA_WIDTH-1:0] i_data_even;
   logic signed [DATA_WIDTH-1:0] i_data_odd;
   logic                         i_valid;
   logic                         o_ready;
   logic signed [COEF_WIDTH-1:0] i_cosine_data;
   logic signed [COEF_WIDTH-1:0] i_sine_data;
   logic signed [COEF_WIDTH-1:0] i_cosine_delay_data;
   logic signed [COEF_WIDTH-1:0] i_sine_delay_data;
   logic                         o_dds_ready;
   logic signed [OUT_WIDTH-1:0]  o_i_even;
   logic signed [OUT_WIDTH-1:0]  o_q_even;
   logic signed [OUT_WIDTH-1:0]  o_i_odd;
   logic signed [OUT_WIDTH-1:0]  o_q_odd;
   logic                         o_valid;
   logic                         i_ready;

   modport master (
      output i_data_even, i_data_odd, i_valid,
      output i_cosine_data, i_sine_data, i_cosine_delay_data, i_sine_delay_data,
      output i_ready,
      input  o_ready, o_dds_ready, o_i_even, o_q_even, o_i_odd, o_q_odd, o_valid
   );

   modport slave (
      input  i_data_even, i_data_odd, i_valid,
      input  i_cosine_data, i_sine_data, i_cosine_delay_data, i_sine_delay_data,
      input  i_ready,
      output o_ready, o_dds_ready, o_i_even, o_q_even, o_i_odd, o_q_odd, o_valid
   );
endinterface

// File: rtl/ddc_mix_lane.sv
// One mixer lane: multiply/negate stage then scale, round and saturate stage, both held by en.
// Rounding mode follows DDC_MIXER_ROUND_EN through ddc_pkg::sat_round.
module ddc_mix_lane
   import ddc_pkg::*;
#(
   parameter int DATA_WIDTH = DDC_DATA_WIDTH,
   parameter int COEF_WIDTH = DDC_COEF_WIDTH,
   parameter int COEF_FRAC  = DDC_COEF_FRAC,
   parameter int OUT_WIDTH  = DDC_OUT_WIDTH
) (
   input  logic                         i_clock,
   input  logic                         i_reset_n,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic signed [COEF_WIDTH-1:0] cosine,
   input  logic signed [COEF_WIDTH-1:0] sine,
   output logic signed [OUT_WIDTH-1:0]  i_out,
   output logic signed [OUT_WIDTH-1:0]  q_out
);
   localparam int PW = DATA_WIDTH + COEF_WIDTH;

   logic signed [PW-1:0] mul_i;
   logic signed [PW-1:0] mul_q;
   logic signed [PW:0]   neg_q;
   logic signed [PW-1:0] prod_i;
   logic signed [PW:0]   prod_q;

   assign mul_i = PW'(x) * PW'(cosine);
   assign mul_q = PW'(x) * PW'(sine);
   // One extra bit so negating the most negative product cannot wrap.
   assign neg_q = -((PW + 1)'(mul_q));

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         prod_i <= '0;
         prod_q <= '0;
         i_out  <= '0;
         q_out  <= '0;
      end else if (en) begin
         prod_i <= mul_i;
         prod_q <= neg_q;
         i_out  <= OUT_WIDTH'(sat_round(DDC_ACC_W'(prod_i), COEF_FRAC, OUT_WIDTH));
         q_out  <= OUT_WIDTH'(sat_round(DDC_ACC_W'(prod_q), COEF_FRAC, OUT_WIDTH));
      end
   end
endmodule

// File: rtl/ddc_mixer_x2.sv
// Two-lane real-to-complex mixer: input register stage, valid pipeline and global stall; lanes do the math.
// Build with DDC_MIXER_ROUND_EN for round-half-up scaling, otherwise floor truncation.
module ddc_mixer_x2
   import ddc_pkg::*;
#(
   parameter int DATA_WIDTH = DDC_DATA_WIDTH,
   parameter int COEF_WIDTH = DDC_COEF_WIDTH,
   parameter int COEF_FRAC  = DDC_COEF_FRAC,
   parameter int OUT_WIDTH  = DDC_OUT_WIDTH
) (
   input logic           i_clock,
   input logic           i_reset_n,
   ddc_mixer_x2_if.slave bus
);
   logic advance;
   logic accept;
   logic v0, v1, v2;
   logic signed [DATA_WIDTH-1:0] x_even, x_odd;
   logic signed [COEF_WIDTH-1:0] cos0, sin0, cos1, sin1;

   assign advance         = !v2 || bus.i_ready;
   assign bus.o_ready     = advance && i_reset_n;
   assign accept          = bus.i_valid && bus.o_ready;
   // The DDS steps only when a pair is taken, so it always presents the word for the next pair.
   assign bus.o_dds_ready = accept;
   assign bus.o_valid     = v2;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         v0     <= 1'b0;
         v1     <= 1'b0;
         v2     <= 1'b0;
         x_even <= '0;
         x_odd  <= '0;
         cos0   <= '0;
         sin0   <= '0;
         cos1   <= '0;
         sin1   <= '0;
      end else if (advance) begin
         v0 <= accept;
         v1 <= v0;
         v2 <= v1;
         if (accept) begin
            x_even <= bus.i_data_even;
            x_odd  <= bus.i_data_odd;
            cos0   <= bus.i_cosine_data;
            sin0   <= bus.i_sine_data;
            cos1   <= bus.i_cosine_delay_data;
            sin1   <= bus.i_sine_delay_data;
         end
      end
   end

   ddc_mix_lane #(
      .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH),
      .COEF_FRAC(COEF_FRAC), .OUT_WIDTH(OUT_WIDTH)
   ) u_lane0 (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .en(advance),
      .x(x_even), .cosine(cos0), .sine(sin0),
      .i_out(bus.o_i_even), .q_out(bus.o_q_even)
   );

   ddc_mix_lane #(
      .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH),
      .COEF_FRAC(COEF_FRAC), .OUT_WIDTH(OUT_WIDTH)
   ) u_lane1 (
      .i_clock(i_clock), .i_reset_n(i_reset_n), .en(advance),
      .x(x_odd), .cosine(cos1), .sine(sin1),
      .i_out(bus.o_i_odd), .q_out(bus.o_q_odd)
   );
endmodule
